puzzle_move_gen: RTL and testbench
==================================

# puzzle_move_gen

Move generator for the 2x4 slider-puzzle board. It drives the board's `from`/`to` move inputs instead of consuming them. It tracks the blank (tile 0) position and accepts single-step or goto commands. Each command is expanded into a sequence of moves that are legal by construction, one move per handshake, so every move it emits satisfies the board's validity predicate. Cells are indexed `{row, col[1:0]}`: 0..3 is the top row, 4..7 is the bottom row.

## Interface
Parameters:
- `INIT_BLANK`, default 0: cell index of the blank after reset.
- `CNT_W`, default 16: width of `move_count`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  1  0 = STEP, 1 = GOTO.
- `cmd_arg`  in  3  STEP: `[1:0]` is the blank direction (0 up, 1 down, 2 left, 3 right); GOTO: target cell.
- `mv_valid`  out  1  move presented.
- `mv_ready`  in  1  board consumes the move.
- `from`  out  3  cell of the tile that slides into the blank.
- `to`  out  3  current blank cell.
- `blank`  out  3  committed blank position.
- `busy`  out  1  a command is in progress.
- `err`  out  1  one-cycle pulse: illegal STEP rejected.
- `move_count`  out  CNT_W  number of moves consumed.

## Operation
- FSM states: IDLE, MOVE.
- `cmd_ready` = (state == IDLE). `busy` = (state == MOVE).
- Direction legality for the blank at (r, c):
  - up is legal iff r = 1.
  - down is legal iff r = 0.
  - left is legal iff c ≠ 0.
  - right is legal iff c ≠ 3.
- Accepted STEP:
  - Legal: load `to` = `blank` and `from` = neighbour, set `mv_valid`, go to MOVE with `walk` = 0.
  - Illegal: pulse `err`, stay in IDLE, emit no move.
- Accepted GOTO:
  - Target == `blank`: the command completes with no move and no `err`.
  - Otherwise: set `walk` = 1, latch the target, and emit the first path move. The path moves horizontally until the column matches, then vertically.
  - A GOTO path is at most 4 moves long.
- In MOVE, on `mv_ready`:
  - `blank` <= `from` and `move_count` increments.
  - If `walk` is set and the new blank ≠ target, present the next move in the following cycle and stay in MOVE.
  - Otherwise return to IDLE and drop `mv_valid`.
- While `mv_valid` is high and `mv_ready` is low, `from` and `to` hold stable.
- `move_count` saturates at all-ones.

## Timing
- Reset values: `mv_valid` 0, `from` 0, `to` 0, `blank` INIT_BLANK, `busy` 0, `err` 0, `move_count` 0, state IDLE (so `cmd_ready` 1).
- All outputs are registered except `cmd_ready` and `busy`, which decode directly from the state register.
- Latency:
  - A command accepted at edge t produces `mv_valid` in cycle t+1.
  - `err` is asserted in cycle t+1 for exactly one cycle.
  - A goto-to-self is complete at t+1, and a new command can be accepted at t+1.
- Throughput: with `mv_ready` tied high, a GOTO emits one move per cycle back-to-back, with no bubble between moves.
- The last move's handshake at edge u returns the FSM to IDLE, so `cmd_ready` is 1 in cycle u+1.
- Reset asserted mid-walk aborts the walk: `blank` returns to INIT_BLANK and any pending move is dropped.

## Configuration
- `PUZZLE_MOVE_GEN_COUNT_EN`:
  - Defined: the `move_count` counter is implemented as described above.
  - Undefined: the counter is removed and `move_count` is tied to 0.
  - All other behaviour is identical in both builds.

## Structure
- Shared package `puzzle_pkg` holds:
  - `cell_t` (3-bit typedef).
  - `dir_e` enum (UP, DOWN, LEFT, RIGHT).
  - `op_e` enum (STEP, GOTO).
  - The FSM state enum.
  - Constants ROWS = 2, COLS = 4.
- One combinational sub-module, `puzzle_next_cell`: inputs (cell, dir), outputs (next cell, legal). It is shared by the STEP path and the GOTO path.

## Test plan
- Reset, then STEP right: move `from`=1, `to`=0 in the cycle after accept; after the handshake `blank`=1 and `move_count`=1.
- Blank=0, STEP up: `err` high for one cycle, no `mv_valid`, `blank` stays 0, and `cmd_ready` is 1 in the next cycle.
- Blank=0, GOTO 7 with `mv_ready`=1: moves (1→0), (2→1), (3→2), (7→3) on four consecutive cycles; `blank`=7; `move_count`=4.
- GOTO 5 from blank 0 with `mv_ready` held low for 3 cycles: `from`=1 and `to`=0 stay stable; the walk completes only after `mv_ready` rises, ending with `blank`=5.
- GOTO to the current blank (blank=3, target 3): no `mv_valid`, no `err`, `cmd_ready` 1 in the next cycle.
- Reset asserted after 2 of 4 GOTO moves: the next cycle shows `mv_valid`=0, `blank`=INIT_BLANK, `move_count`=0. With `PUZZLE_MOVE_GEN_COUNT_EN` undefined, `move_count` stays 0 throughout.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared types for the 2x4 slider-puzzle move generator: cells, directions,
// command opcodes, FSM states and the GOTO path-direction helper.
package puzzle_pkg;

    localparam int ROWS = 2;
    localparam int COLS = 4;

    typedef logic [2:0] cell_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    typedef enum logic {
        STEP = 1'b0,
        GOTO = 1'b1
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MOVE = 1'b1
    } state_e;

    // Column is closed first, then the single row change.
    function automatic dir_e path_dir(input cell_t cur, input cell_t tgt);
        if (cur[1:0] < tgt[1:0])
            return RIGHT;
        else if (cur[1:0] > tgt[1:0])
            return LEFT;
        else if (cur[2])
            return UP;
        else
            return DOWN;
    endfunction

endpackage

// File: rtl/puzzle_next_cell.sv
// Combinational neighbour lookup: where the blank lands when it moves in a
// given direction, and whether that move stays on the 2x4 board.
module puzzle_next_cell
    import puzzle_pkg::*;
(
    input  cell_t i_cell,
    input  dir_e  i_dir,
    output cell_t o_next,
    output logic  o_legal
);

    logic       w_row;
    logic [1:0] w_col;

    assign w_row = i_cell[2];
    assign w_col = i_cell[1:0];

    always_comb begin
        o_next  = i_cell;
        o_legal = 1'b0;
        unique case (i_dir)
            UP: begin
                o_legal = (w_row == 1'(ROWS - 1));
                o_next  = i_cell - cell_t'(COLS);
            end
            DOWN: begin
                o_legal = (w_row == 1'b0);
                o_next  = i_cell + cell_t'(COLS);
            end
            LEFT: begin
                o_legal = (w_col != 2'd0);
                o_next  = i_cell - cell_t'(1);
            end
            RIGHT: begin
                o_legal = (w_col != 2'(COLS - 1));
                o_next  = i_cell + cell_t'(1);
            end
        endcase
    end

endmodule

// File: rtl/puzzle_move_gen.sv
// Move generator for the 2x4 slider puzzle: expands STEP/GOTO commands into
// legal moves, one per handshake. Macro PUZZLE_MOVE_GEN_COUNT_EN enables move_count.
module puzzle_move_gen
    import puzzle_pkg::*;
#(
    parameter int INIT_BLANK = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [2:0]       cmd_arg,
    output logic             mv_valid,
    input  logic             mv_ready,
    output logic [2:0]       from,
    output logic [2:0]       to,
    output logic [2:0]       blank,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] move_count
);

    localparam cell_t INIT_CELL = cell_t'(INIT_BLANK);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_walk;
    cell_t  r_target;
    cell_t  r_blank;
    cell_t  r_from;
    cell_t  r_to;
    logic   r_mv_valid;
    logic   r_err;

    cell_t  w_cell;
    cell_t  w_tgt;
    dir_e   w_dir;
    cell_t  w_next;
    logic   w_legal;
    logic   w_load;
    logic   w_err_nxt;
    logic   w_accept;
    logic   w_hs;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_hs     = mv_ready && (r_state == S_MOVE);

    // In IDLE the lookup starts from the committed blank; in MOVE it starts
    // from the cell the blank occupies once the pending move is consumed.
    always_comb begin
        w_cell = r_blank;
        w_tgt  = cmd_arg;
        if (r_state == S_MOVE) begin
            w_cell = r_from;
            w_tgt  = r_target;
        end
        w_dir = path_dir(w_cell, w_tgt);
        if (r_state == S_IDLE && op_e'(cmd_op) == STEP)
            w_dir = dir_e'(cmd_arg[1:0]);
    end

    puzzle_next_cell u_next_cell (
        .i_cell  (w_cell),
        .i_dir   (w_dir),
        .o_next  (w_next),
        .o_legal (w_legal)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (op_e'(cmd_op) == STEP) begin
                        if (w_legal) begin
                            w_load      = 1'b1;
                            w_state_nxt = S_MOVE;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (cmd_arg != r_blank) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_MOVE;
                    end
                end
            end
            S_MOVE: begin
                if (mv_ready) begin
                    if (r_walk && (r_from != r_target))
                        w_load = 1'b1;
                    else
                        w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_walk     <= 1'b0;
            r_target   <= '0;
            r_blank    <= INIT_CELL;
            r_from     <= '0;
            r_to       <= '0;
            r_mv_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_err      <= w_err_nxt;
            r_mv_valid <= (w_state_nxt == S_MOVE);
            if (w_hs)
                r_blank <= r_from;
            if (w_load) begin
                r_to   <= w_cell;
                r_from <= w_next;
            end
            if (w_accept) begin
                r_walk   <= (op_e'(cmd_op) == GOTO);
                r_target <= cmd_arg;
            end
        end
    end

`ifdef PUZZLE_MOVE_GEN_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset)
            r_count <= '0;
        else if (w_hs && (r_count != '1))
            r_count <= r_count + CNT_W'(1);
    end

    assign move_count = r_count;
`else
    assign move_count = '0;
`endif

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_MOVE);
    assign mv_valid  = r_mv_valid;
    assign from      = r_from;
    assign to        = r_to;
    assign blank     = r_blank;
    assign err       = r_err;

endmodule

// File: tb/tb_puzzle_move_gen.sv
// Self-checking bench for puzzle_move_gen: directed command table, stall and
// mid-walk reset sequences, then random commands against a board-level model.
module tb_puzzle_move_gen;

    localparam int CNT_W = 16;

    logic             clock;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [2:0]       cmd_arg;
    logic             mv_valid;
    logic             mv_ready;
    logic [2:0]       from;
    logic [2:0]       to;
    logic [2:0]       blank;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] move_count;

    int total;
    int bad;
    int m_blank;
    int m_cnt;

    puzzle_move_gen #(.INIT_BLANK(0), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .mv_valid   (mv_valid),
        .mv_ready   (mv_ready),
        .from       (from),
        .to         (to),
        .blank      (blank),
        .busy       (busy),
        .err        (err),
        .move_count (move_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
`ifdef PUZZLE_MOVE_GEN_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Board model: builds the expected move list from row/column arithmetic,
    // then drives the command and checks every move the DUT presents.
    task automatic run_cmd(input bit op, input int arg, input int stall, output bit got_err);
        int  mf[$];
        int  mt[$];
        int  r, c, tr, tc, nc;
        bit  ex_err;
        ex_err = 1'b0;
        r = m_blank / 4;
        c = m_blank % 4;
        if (op == 1'b0) begin
            case (arg % 4)
                0: if (r == 1) mf.push_back(m_blank - 4); else ex_err = 1'b1;
                1: if (r == 0) mf.push_back(m_blank + 4); else ex_err = 1'b1;
                2: if (c != 0) mf.push_back(m_blank - 1); else ex_err = 1'b1;
                default: if (c != 3) mf.push_back(m_blank + 1); else ex_err = 1'b1;
            endcase
            if (!ex_err) mt.push_back(m_blank);
        end else begin
            tr = arg / 4;
            tc = arg % 4;
            while (c != tc) begin
                nc = (c < tc) ? c + 1 : c - 1;
                mt.push_back(r * 4 + c);
                mf.push_back(r * 4 + nc);
                c = nc;
            end
            if (r != tr) begin
                mt.push_back(r * 4 + c);
                mf.push_back(tr * 4 + c);
            end
        end

        chk("cmd_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg[2:0];
        step();
        cmd_valid = 1'b0;
        got_err = err;
        chk("err_after_accept", err, ex_err);
        if (ex_err) begin
            chk("err_no_move", mv_valid, 0);
            step();
            chk("err_one_cycle", err, 0);
        end
        foreach (mf[i]) begin
            chk("mv_valid", mv_valid, 1);
            chk("busy", busy, 1);
            chk("cmd_ready_busy", cmd_ready, 0);
            chk("from", from, mf[i]);
            chk("to", to, mt[i]);
            for (int s = 0; s < stall; s++) begin
                mv_ready = 1'b0;
                step();
                chk("stall_valid", mv_valid, 1);
                chk("stall_from", from, mf[i]);
                chk("stall_to", to, mt[i]);
            end
            mv_ready = 1'b1;
            step();
            mv_ready = 1'b0;
            m_blank = mf[i];
            m_cnt++;
        end
        chk("mv_valid_done", mv_valid, 0);
        chk("cmd_ready_done", cmd_ready, 1);
        chk("blank", blank, m_blank);
        chk("move_count", move_count, exp_cnt());
    endtask

    typedef struct {
        bit op;
        int arg;
        int stall;
        bit exp_err;
        int exp_blank;
    } vec_t;

    vec_t tbl[11];
    bit   e;

    initial begin
        total = 0;
        bad   = 0;
        m_blank = 0;
        m_cnt   = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_arg   = '0;
        mv_ready  = 1'b0;

        tbl[0]  = '{1'b0, 3, 0, 1'b0, 1};
        tbl[1]  = '{1'b0, 2, 0, 1'b0, 0};
        tbl[2]  = '{1'b0, 0, 0, 1'b1, 0};
        tbl[3]  = '{1'b1, 7, 0, 1'b0, 7};
        tbl[4]  = '{1'b0, 1, 0, 1'b1, 7};
        tbl[5]  = '{1'b0, 2, 0, 1'b0, 6};
        tbl[6]  = '{1'b1, 0, 2, 1'b0, 0};
        tbl[7]  = '{1'b1, 5, 3, 1'b0, 5};
        tbl[8]  = '{1'b1, 3, 1, 1'b0, 3};
        tbl[9]  = '{1'b1, 3, 0, 1'b0, 3};
        tbl[10] = '{1'b0, 3, 0, 1'b1, 3};

        step();
        step();
        chk("rst_mv_valid", mv_valid, 0);
        chk("rst_from", from, 0);
        chk("rst_to", to, 0);
        chk("rst_blank", blank, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_move_count", move_count, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            run_cmd(tbl[i].op, tbl[i].arg, tbl[i].stall, e);
            chk("tbl_err", e, tbl[i].exp_err);
            chk("tbl_blank", blank, tbl[i].exp_blank);
        end

        // Abort a four-move GOTO after two handshakes.
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_blank = 0;
        m_cnt   = 0;
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_arg   = 3'd7;
        step();
        cmd_valid = 1'b0;
        mv_ready  = 1'b1;
        step();
        step();
        chk("midwalk_valid", mv_valid, 1);
        chk("midwalk_from", from, 3);
        chk("midwalk_blank", blank, 2);
`ifdef PUZZLE_MOVE_GEN_COUNT_EN
        chk("midwalk_count", move_count, 2);
`else
        chk("midwalk_count", move_count, 0);
`endif
        reset    = 1'b1;
        mv_ready = 1'b0;
        step();
        chk("abort_mv_valid", mv_valid, 0);
        chk("abort_blank", blank, 0);
        chk("abort_move_count", move_count, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        step();

        for (int n = 0; n < 60; n++) begin
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 2)), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
